// File: rtl/lf_spi_cmd_decoder_pkg.sv
// lf_spi_cmd_decoder_pkg
// Shared LF FPGA definitions: ARM command codes, major-mode codes, LF option
// bit positions, frame geometry and the decoder FSM state type.
package lf_spi_cmd_decoder_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG                = 4'h1;
  localparam logic [3:0] FPGA_CMD_SET_DIVISOR                = 4'h2;
  localparam logic [3:0] FPGA_CMD_SET_EDGE_DETECT_THRESHOLD  = 4'h3;

  localparam logic [2:0] FPGA_MAJOR_MODE_LF_ADC              = 3'd0;
  localparam logic [2:0] FPGA_MAJOR_MODE_LF_EDGE_DETECT      = 3'd1;
  localparam logic [2:0] FPGA_MAJOR_MODE_LF_PASSTHRU         = 3'd2;

  localparam int LF_MAJOR_MODE_LSB    = 6;
  localparam int LF_TOGGLE_MODE_BIT   = 1;
  localparam int LF_READER_FIELD_BIT  = 0;

  localparam logic [7:0] LF_DEFAULT_DIVISOR   = 8'd95;
  localparam logic [7:0] LF_DEFAULT_THRESHOLD = 8'd127;

  localparam logic [4:0] FRAME_BITS   = 5'd16;
  localparam logic [4:0] BIT_CNT_SAT  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  function automatic logic [4:0] bit_cnt_inc(input logic [4:0] cnt);
    return (cnt == BIT_CNT_SAT) ? cnt : cnt + 5'd1;
  endfunction

endpackage

// File: rtl/lf_spi_cmd_decoder_sync_edge.sv
// lf_spi_cmd_decoder_sync_edge
// Multi-flop synchroniser for one asynchronous pin, followed by one history
// flop that yields single-cycle rise/fall pulses in the clock domain.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (all flops load RST_VAL)
//   i_d      asynchronous input pin
//   o_sync   synchronised level
//   o_rise   one-cycle pulse on synchronised 0->1
//   o_fall   one-cycle pulse on synchronised 1->0
module lf_spi_cmd_decoder_sync_edge #(
  parameter int   STAGES  = 2,     // minimum 2
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise =  o_sync & ~r_prev;
  assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/lf_spi_cmd_decoder.sv
// lf_spi_cmd_decoder
// Receives 16-bit ARM command frames on spck/mosi/ncs, synchronises them into
// the pck0 domain, rejects frames that are not exactly 16 bits, and decodes
// SET_CONFREG / SET_DIVISOR / SET_EDGE_DETECT_THRESHOLD into registered
// configuration outputs.
// Optional feature macro: FPGA_CMD_READBACK_EN (status word shifted out on
// miso during each frame; without it miso is tied low).
// Ports:
//   i_pck0             system clock, rising edge
//   i_nreset           asynchronous active-low reset
//   i_spck             SPI clock (asynchronous, <= pck0/4)
//   i_mosi             SPI data, sampled on spck rise
//   i_ncs              SPI chip select, active low
//   o_miso             SPI readback data
//   o_conf_word[8:0]   [8:6] major mode, [1] toggle mode, [0] reader field
//   o_divisor[7:0]     clk_divider divide value
//   o_lf_ed_threshold  edge-detect threshold
//   o_cfg_strobe       one-cycle pulse on any register update
//   o_frame_err        one-cycle pulse on a frame not exactly 16 bits
//
// state  | meaning
// IDLE   | waiting for ncs fall (or a fall latched during DECODE)
// SHIFT  | collecting mosi bits on spck rise until ncs rises
// DECODE | one cycle: apply command or flag frame error
module lf_spi_cmd_decoder
  import lf_spi_cmd_decoder_pkg::*;
#(
  parameter int         SYNC_STAGES       = 2,
  parameter logic [7:0] DEFAULT_DIVISOR   = LF_DEFAULT_DIVISOR,
  parameter logic [7:0] DEFAULT_THRESHOLD = LF_DEFAULT_THRESHOLD
) (
  input  logic       i_pck0,
  input  logic       i_nreset,
  input  logic       i_spck,
  input  logic       i_mosi,
  input  logic       i_ncs,
  output logic       o_miso,
  output logic [8:0] o_conf_word,
  output logic [7:0] o_divisor,
  output logic [7:0] o_lf_ed_threshold,
  output logic       o_cfg_strobe,
  output logic       o_frame_err
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SYNC_STAGES + 1);

  logic w_spck_sync, w_spck_rise, w_spck_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
  logic w_ncs_sync,  w_ncs_rise,  w_ncs_fall;

  lf_spi_cmd_decoder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_spck (
    .i_clk(i_pck0), .i_rst_n(i_nreset), .i_d(i_spck),
    .o_sync(w_spck_sync), .o_rise(w_spck_rise), .o_fall(w_spck_fall));

  lf_spi_cmd_decoder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_pck0), .i_rst_n(i_nreset), .i_d(i_mosi),
    .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  lf_spi_cmd_decoder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .i_clk(i_pck0), .i_rst_n(i_nreset), .i_d(i_ncs),
    .o_sync(w_ncs_sync), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall));

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_shift;
  logic [4:0]           r_bit_cnt;
  logic [8:0]           r_conf;
  logic [7:0]           r_div;
  logic [7:0]           r_thr;
  logic                 r_strobe;
  logic                 r_err;
  logic                 r_fall_pend;
  logic [SETTLE_W-1:0]  r_settle;
  logic                 r_armed;

  logic w_ncs_start, w_start, w_shift_en, w_decode_ok, w_decode_bad;

  // The ncs synchroniser resets high, so a pin already low at reset release
  // would look like a falling edge. Frame starts are only accepted once the
  // synchroniser has flushed and ncs has been seen high (idle bus).
  always_ff @(posedge i_pck0 or negedge i_nreset) begin
    if (!i_nreset) begin
      r_settle <= SETTLE_LOAD;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != '0) r_settle <= r_settle - 1'b1;
      if (r_settle == '0 && w_ncs_sync) r_armed <= 1'b1;
    end
  end

  assign w_ncs_start = w_ncs_fall & r_armed;

  always_ff @(posedge i_pck0 or negedge i_nreset) begin
    if (!i_nreset) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_shift_en   = 1'b0;
    w_decode_ok  = 1'b0;
    w_decode_bad = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_start || r_fall_pend) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        // ncs rise wins over a coincident spck rise; that bit is dropped.
        if (w_ncs_rise)       w_state_nxt = ST_DECODE;
        else if (w_spck_rise) w_shift_en  = 1'b1;
      end
      ST_DECODE: begin
        w_state_nxt = ST_IDLE;
        if (r_bit_cnt == FRAME_BITS) w_decode_ok  = 1'b1;
        else                         w_decode_bad = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pck0 or negedge i_nreset) begin
    if (!i_nreset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_conf      <= '0;
      r_div       <= DEFAULT_DIVISOR;
      r_thr       <= DEFAULT_THRESHOLD;
      r_strobe    <= 1'b0;
      r_err       <= 1'b0;
      r_fall_pend <= 1'b0;
    end else begin
      // A new frame starting during DECODE is picked up from IDLE next cycle.
      r_fall_pend <= (r_state == ST_DECODE) && w_ncs_start;
      r_strobe    <= 1'b0;
      r_err       <= w_decode_bad;

      if (w_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift   <= {r_shift[14:0], w_mosi_sync};
        r_bit_cnt <= bit_cnt_inc(r_bit_cnt);
      end

      if (w_decode_ok) begin
        case (r_shift[15:12])
          FPGA_CMD_SET_CONFREG: begin
            r_conf   <= r_shift[8:0];
            r_strobe <= 1'b1;
            // Entering edge-detect mode restarts from the default threshold.
            if (r_shift[8:6] == FPGA_MAJOR_MODE_LF_EDGE_DETECT)
              r_thr <= DEFAULT_THRESHOLD;
          end
          FPGA_CMD_SET_DIVISOR: begin
            r_div    <= r_shift[7:0];
            r_strobe <= 1'b1;
          end
          FPGA_CMD_SET_EDGE_DETECT_THRESHOLD: begin
            r_thr    <= r_shift[7:0];
            r_strobe <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_conf_word       = r_conf;
  assign o_divisor         = r_div;
  assign o_lf_ed_threshold = r_thr;
  assign o_cfg_strobe      = r_strobe;
  assign o_frame_err       = r_err;

`ifdef FPGA_CMD_READBACK_EN
  logic [15:0] r_tx;
  logic [3:0]  r_err_cnt;

  always_ff @(posedge i_pck0 or negedge i_nreset) begin
    if (!i_nreset) begin
      r_tx      <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_start)
        r_tx <= {r_err_cnt, 3'b000, r_conf};
      else if (r_state == ST_SHIFT && w_spck_fall)
        r_tx <= {r_tx[14:0], 1'b0};
      if (w_decode_bad && r_err_cnt != 4'hF)
        r_err_cnt <= r_err_cnt + 4'd1;
    end
  end

  assign o_miso = (r_state == ST_SHIFT) & r_tx[15];

  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_spck_sync, w_mosi_rise, w_mosi_fall};
`else
  assign o_miso = 1'b0;

  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_spck_sync, w_spck_fall, w_mosi_rise, w_mosi_fall};
`endif

endmodule

// File: tb/tb_lf_spi_cmd_decoder.sv
module tb_lf_spi_cmd_decoder;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic       clk = 1'b0;
  logic       i_nreset, i_spck, i_mosi, i_ncs;
  logic       o_miso, o_cfg_strobe, o_frame_err;
  logic [8:0] o_conf_word;
  logic [7:0] o_divisor, o_lf_ed_threshold;

  always #5 clk = ~clk;

  lf_spi_cmd_decoder #(.SYNC_STAGES(SYNC), .DEFAULT_DIVISOR(8'd95), .DEFAULT_THRESHOLD(8'd127)) dut (
    .i_pck0(clk), .i_nreset(i_nreset), .i_spck(i_spck), .i_mosi(i_mosi), .i_ncs(i_ncs),
    .o_miso(o_miso), .o_conf_word(o_conf_word), .o_divisor(o_divisor),
    .o_lf_ed_threshold(o_lf_ed_threshold), .o_cfg_strobe(o_cfg_strobe), .o_frame_err(o_frame_err));

  typedef struct { int due; logic [15:0] word; int nbits; } ev_t;
  ev_t q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int n_strobe = 0, n_err = 0;
  int last_strobe_cyc = -1, last_rise_cyc = 0;

  // Model of the architectural registers.
  logic [8:0] m_conf = 9'h000;
  logic [7:0] m_div  = 8'd95;
  logic [7:0] m_thr  = 8'd127;
  logic [3:0] m_errc = 4'd0;
  logic       m_strobe, m_err;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_conf = 9'h000; m_div = 8'd95; m_thr = 8'd127; m_errc = 4'd0;
  endtask

  task automatic model_apply(input ev_t e);
    if (e.nbits != 16) begin
      m_err = 1'b1;
      if (m_errc != 4'hF) m_errc = m_errc + 4'd1;
    end else begin
      case (e.word[15:12])
        4'h1: begin
          m_conf = e.word[8:0]; m_strobe = 1'b1;
          if (e.word[8:6] == 3'd1) m_thr = 8'd127;
        end
        4'h2: begin m_div = e.word[7:0]; m_strobe = 1'b1; end
        4'h3: begin m_thr = e.word[7:0]; m_strobe = 1'b1; end
        default: ;
      endcase
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk); #1;
      m_strobe = 1'b0; m_err = 1'b0;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        model_apply(e);
      end
      check("conf_word", 32'(o_conf_word), 32'(m_conf));
      check("divisor", 32'(o_divisor), 32'(m_div));
      check("threshold", 32'(o_lf_ed_threshold), 32'(m_thr));
      check("cfg_strobe", 32'(o_cfg_strobe), 32'(m_strobe));
      check("frame_err", 32'(o_frame_err), 32'(m_err));
`ifndef FPGA_CMD_READBACK_EN
      check("miso_idle", 32'(o_miso), 32'd0);
`endif
      if (o_cfg_strobe) begin n_strobe++; last_strobe_cyc = cyc; end
      if (o_frame_err) n_err++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the low nbits of val MSB first, spck = pck0/8. Optionally captures
  // miso just before each of the first 16 spck rises.
  task automatic send_frame(input logic [31:0] val, input int nbits,
                            input logic do_read, output logic [15:0] rd);
    ev_t e;
    rd = 16'h0;
    i_ncs = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      i_mosi = val[i];
      tick(4);
      if (do_read && (nbits - 1 - i) < 16) rd = {rd[14:0], o_miso};
      i_spck = 1'b1;
      tick(4);
      i_spck = 1'b0;
    end
    tick(4);
    i_ncs = 1'b1;
    i_mosi = 1'b0;
    last_rise_cyc = cyc;
    e.due = cyc + LAT; e.word = val[15:0]; e.nbits = nbits;
    q.push_back(e);
    tick(12);
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  part;
    i_nreset = 1'b0; i_ncs = 1'b1; i_spck = 1'b0; i_mosi = 1'b0;
    tick(3);
    check("rst_conf", 32'(o_conf_word), 32'h000);
    check("rst_div", 32'(o_divisor), 32'd95);
    check("rst_thr", 32'(o_lf_ed_threshold), 32'd127);
    check("rst_miso", 32'(o_miso), 32'd0);
    i_nreset = 1'b1;
    tick(10);

    send_frame(32'h2040, 16, 1'b0, rd);
    check("div_2040", 32'(o_divisor), 32'h40);
    check("strobe_cnt_1", 32'(n_strobe), 32'd1);
    check("strobe_latency", 32'(last_strobe_cyc - last_rise_cyc), 32'd4);

    send_frame(32'h3055, 16, 1'b0, rd);
    check("thr_3055", 32'(o_lf_ed_threshold), 32'h55);
    send_frame(32'h1042, 16, 1'b0, rd);
    check("conf_1042", 32'(o_conf_word), 32'h042);
    check("thr_reload", 32'(o_lf_ed_threshold), 32'd127);
    check("strobe_cnt_3", 32'(n_strobe), 32'd3);

    send_frame(32'h2010, 15, 1'b0, rd);
    send_frame(32'h02010, 17, 1'b0, rd);
    check("err_cnt_2", 32'(n_err), 32'd2);
    check("div_kept", 32'(o_divisor), 32'h40);
    check("strobe_cnt_kept", 32'(n_strobe), 32'd3);

    // Reset in the middle of 0x20FF, released with ncs still low.
    part = 8'h20;
    i_ncs = 1'b0;
    tick(4);
    for (int i = 7; i >= 0; i--) begin
      i_mosi = part[i];
      tick(4); i_spck = 1'b1; tick(4); i_spck = 1'b0;
    end
    i_nreset = 1'b0;
    model_reset();
    tick(3);
    i_nreset = 1'b1;
    tick(10);
    i_ncs = 1'b1;
    i_mosi = 1'b0;
    tick(12);
    check("midrst_div", 32'(o_divisor), 32'd95);
    check("midrst_conf", 32'(o_conf_word), 32'h000);
    check("midrst_thr", 32'(o_lf_ed_threshold), 32'd127);
    check("midrst_err", 32'(n_err), 32'd2);
    check("midrst_strobe", 32'(n_strobe), 32'd3);

    send_frame(32'h2007, 16, 1'b0, rd);
    check("div_2007", 32'(o_divisor), 32'd7);

    send_frame(32'h00, 8, 1'b0, rd);
    send_frame(32'h1081, 16, 1'b0, rd);
    check("conf_081", 32'(o_conf_word), 32'h081);
    check("thr_not_reload", 32'(o_lf_ed_threshold), 32'd127);
    send_frame(32'h0000, 16, 1'b1, rd);
`ifdef FPGA_CMD_READBACK_EN
    check("readback_lit", 32'(rd), 32'h1081);
    check("readback_model", 32'(rd), 32'({m_errc, 3'b000, m_conf}));
`else
    check("readback_off", 32'(rd), 32'h0000);
`endif
    check("strobe_cnt_end", 32'(n_strobe), 32'd5);

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
